// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction classes, opcodes, loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_J     = 3'd4,
    CLS_ADDI  = 3'd5
  } instr_cls_e;

  // Primary opcode field values, identical to those the main decoder matches
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_enc.sv
// Packs class + register/immediate fields into a 32-bit MIPS word; flags illegal classes.
// Latency: purely combinational.
// Backpressure: none.
module instr_enc
  import mips_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the field layout for the class; classes 6 and 7 produce a zero word
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      CLS_LW:    word = {OP_LW, rs, rt, imm};
      CLS_SW:    word = {OP_SW, rs, rt, imm};
      CLS_BEQ:   word = {OP_BEQ, rs, rt, imm};
      CLS_J:     word = {OP_J, target};
      CLS_ADDI:  word = {OP_ADDI, rs, rt, imm};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_loader_enc.sv
// Accepts instruction-field beats, encodes them and writes them sequentially into imem.
// Latency: write strobe one cycle after the accepting edge; one beat per cycle.
// Backpressure: ready_o low outside LOAD and once the last imem word has been written.
module imem_loader_enc
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        cls_i3,
  input  logic [4:0]        rs_i5,
  input  logic [4:0]        rt_i5,
  input  logic [4:0]        rd_i5,
  input  logic [5:0]        funct_i6,
  input  logic [15:0]       imm_i16,
  input  logic [25:0]       target_i26,
  input  logic              last_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o32,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WORD = '1;

  ld_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;

  instr_enc u_enc (
    .cls     (cls_i3),
    .rs      (rs_i5),
    .rt      (rt_i5),
    .rd      (rd_i5),
    .funct   (funct_i6),
    .imm     (imm_i16),
    .target  (target_i26),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Refuse beats while the write to the final imem word is still on the port
  assign ready_o = (state == ST_LOAD) && !(we_o && (waddr_o == LAST_WORD));
  assign accept  = valid_i && ready_o;

  // Session FSM with address/count bookkeeping and the registered write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      addr      <= BASE_WORD;
      count_o   <= '0;
      we_o      <= 1'b0;
      waddr_o   <= '0;
      wdata_o32 <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state   <= ST_LOAD;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            addr    <= BASE_WORD;
            count_o <= '0;
            err_o   <= 1'b0;
            ovf_o   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              err_o <= 1'b1;
              if (last_i) begin
                state  <= ST_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end
            end else begin
              we_o      <= 1'b1;
              waddr_o   <= addr;
              wdata_o32 <= enc_word;
              count_o   <= count_o + (ADDR_W+1)'(1);
              // The address saturates at the top word rather than wrapping
              if (addr != LAST_WORD) addr <= addr + ADDR_W'(1);
              if (last_i || (addr == LAST_WORD)) begin
                state  <= ST_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end
              if (!last_i && (addr == LAST_WORD)) ovf_o <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
